bernoulli_lfsr_array: RTL and testbench
=======================================

// Module: bernoulli_lfsr_array
// PURPOSE
//  Multi-channel Bernoulli spike source. Each of OUTPUTS channels emits a registered bit.
//  The bit is 1 with probability thr[i]/2^WIDTH; a thr of all-ones gives probability 1.
//  Per-channel LFSRs, run-time threshold update and seed reload supersede the fixed-U/7-bit generators.
//  Drives stochastic input spikes and STDP coin flips in the TNN column.
// PARAMETERS
//  OUTPUTS   4        number of independent channels
//  WIDTH     7        threshold / random-sample width; requires WIDTH <= LFSR_W
//  LFSR_W    16       per-channel Galois LFSR width; taps from bernoulli_pkg, max-length, 8..32
//  SEED_BASE 16'hACE1 reset seed, truncated/zero-extended to LFSR_W; must be nonzero
//  WINDOW    1024     stats window in samples (BERN_STATS_EN only); >= 1
// PORTS
//  clk        in  1                 clock
//  rst        in  1                 async active-high reset
//  en         in  1                 advance all LFSRs and take one sample this cycle
//  seed_load  in  1                 reseed all channels from seed this cycle
//  seed       in  LFSR_W            seed value
//  thr_we     in  1                 capture thr_in into threshold registers
//  thr_in     in  OUTPUTS x WIDTH   packed [0:OUTPUTS-1][WIDTH-1:0] thresholds
//  out        out OUTPUTS           Bernoulli bits, [0:OUTPUTS-1]
//  out_valid  out 1                 out holds a sample taken on the previous en cycle
//  stats_cnt  out OUTPUTS x CNT_W   ones per channel over last window (BERN_STATS_EN only)
//  stats_valid out 1                1-cycle pulse when stats_cnt updates (BERN_STATS_EN only)
// BEHAVIOUR
//  Reset (async, any time, mid-operation included):
//   - lfsr[i] = SEED_BASE ^ salt(i). If the result is 0, lfsr[i] = SEED_BASE.
//   - thr[i] = 0; out = 0; out_valid = 0; all stats state = 0.
//  Priority per cycle: seed_load > en.
//   - seed_load=1: lfsr[i] <= seed ^ salt(i), with the same zero substitution. No sample; out_valid <= 0.
//   - en=1 (and no seed_load): lfsr[i] <= step(lfsr[i]); r_i = step(lfsr[i])[WIDTH-1:0].
//     out[i] <= (r_i < thr[i]) | (thr[i] == '1); out_valid <= 1.
//   - en=0: out holds its value; out_valid <= 0; the LFSR holds.
//  Latency: en at edge k -> out valid after edge k (1 cycle). One sample per en.
//  thr_we: thr <= thr_in at the edge. A sample taken in the same cycle uses the OLD thr;
//   the new thr applies from the next en. thr_we is independent of seed_load and en.
//  Boundaries:
//   - thr=0 -> out always 0. thr='1 -> out always 1.
//   - thr=2^(WIDTH-1) -> ~50%.
//   - The LFSR never reaches 0 (zero substitution). The period is 2^LFSR_W-1 for every channel.
//  Compare is unsigned WIDTH-bit; no arithmetic overflow paths.
// CONFIGURATION
//  BERN_STATS_EN defined:
//   - Per-channel ones counters, CNT_W = $clog2(WINDOW+1) bits, plus a sample counter.
//   - Both count en samples only.
//   - On the WINDOW-th sample: stats_cnt <= counts including that sample; stats_valid=1 for 1 cycle;
//     all counters clear.
//   - seed_load clears the counters without pulsing stats_valid.
//  BERN_STATS_EN undefined: stats ports and counters absent; all other behaviour identical.
// STRUCTURE
//  bernoulli_pkg:
//   - lfsr_taps(LFSR_W) function; salt(i) = i * 16'h9E37 truncated to LFSR_W.
//   - typedefs thr_t [WIDTH-1:0], lfsr_t [LFSR_W-1:0].
//  Sub-module bernoulli_lfsr (one channel): clk, rst, load, load_val, step, state.
//   - Generated OUTPUTS times.
//   - The top holds the threshold registers, compare, output registers and stats.
// TESTING
//  - thr={0,64,96,127}, W=7, 10000 en cycles:
//    ch0 = 0 ones; ch1 = 5000+-300; ch2 = 7500+-300; ch3 = 10000.
//  - seed_load seed=16'h1234, capture 256 outputs; repeat the load
//    -> bit-identical 256-sample sequence; ch0 and ch1 sequences differ.
//  - seed_load seed=salt(0):
//    -> lfsr[0] = SEED_BASE (not 0); out[0] toggles within 64 samples at thr=64.
//  - thr_we and en in the same cycle, thr 0->127:
//    -> that sample is 0; the next sample is 1.
//  - Assert rst mid-run with en=1 for 1 cycle:
//    -> out=0 and out_valid=0 immediately (async); first 32 post-reset samples match a fresh-reset run.
//  - BERN_STATS_EN, WINDOW=16, thr ch0=127, en continuous:
//    -> stats_valid pulses every 16 cycles with stats_cnt[0]=16.
//  - BERN_STATS_EN: en gapped 50% -> stats_valid pulses every 32 cycles.

Source files
------------

// File: rtl/bernoulli_pkg.sv
// Shared types and LFSR helpers for the Bernoulli spike source array.
// Galois right-shift LFSR: feedback mask applied when the bit shifted out is 1.
package bernoulli_pkg;

    localparam int BERN_WIDTH  = 7;
    localparam int BERN_LFSR_W = 16;

    typedef logic [BERN_WIDTH-1:0]  thr_t;
    typedef logic [BERN_LFSR_W-1:0] lfsr_t;

    // Maximal-length feedback masks for widths 8..32.
    function automatic logic [31:0] lfsr_taps(input int w);
        case (w)
            8:       return 32'h0000_00B8;
            9:       return 32'h0000_0110;
            10:      return 32'h0000_0240;
            11:      return 32'h0000_0500;
            12:      return 32'h0000_0829;
            13:      return 32'h0000_100D;
            14:      return 32'h0000_2015;
            15:      return 32'h0000_6000;
            16:      return 32'h0000_B400;
            17:      return 32'h0001_2000;
            18:      return 32'h0002_0400;
            19:      return 32'h0004_0023;
            20:      return 32'h0009_0000;
            21:      return 32'h0014_0000;
            22:      return 32'h0030_0000;
            23:      return 32'h0042_0000;
            24:      return 32'h00E1_0000;
            25:      return 32'h0120_0000;
            26:      return 32'h0200_0023;
            27:      return 32'h0400_0013;
            28:      return 32'h0900_0000;
            29:      return 32'h1400_0000;
            30:      return 32'h2000_0029;
            31:      return 32'h4800_0000;
            32:      return 32'h8020_0003;
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic [31:0] salt(input int i);
        return 32'(i) * 32'h0000_9E37;
    endfunction

    function automatic logic [31:0] lfsr_step(input logic [31:0] s, input int w);
        return (s >> 1) ^ (s[0] ? lfsr_taps(w) : 32'h0);
    endfunction

endpackage

// File: rtl/bernoulli_lfsr.sv
// One Galois LFSR channel with synchronous reload; load wins over step.
module bernoulli_lfsr
    import bernoulli_pkg::*;
#(
    parameter int                LFSR_W    = 16,
    parameter logic [LFSR_W-1:0] RESET_VAL = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [LFSR_W-1:0] load_val,
    input  logic              step,
    output logic [LFSR_W-1:0] state
);

    // NOTE: sequential state uses <= so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= RESET_VAL;
        end else if (load) begin
            state <= load_val;
        end else if (step) begin
            state <= LFSR_W'(lfsr_step(32'(state), LFSR_W));
        end
    end

endmodule

// File: rtl/bernoulli_lfsr_array.sv
// Multi-channel Bernoulli spike source: out[i]=1 with probability thr[i]/2^WIDTH.
// Optional per-window ones statistics are built when BERN_STATS_EN is defined.
module bernoulli_lfsr_array
    import bernoulli_pkg::*;
#(
    parameter int          OUTPUTS   = 4,
    parameter int          WIDTH     = 7,
    parameter int          LFSR_W    = 16,
    parameter logic [31:0] SEED_BASE = 32'h0000_ACE1,
    parameter int          WINDOW    = 1024,
    localparam int         CNT_W     = $clog2(WINDOW + 1)
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            en,
    input  logic                            seed_load,
    input  logic [LFSR_W-1:0]               seed,
    input  logic                            thr_we,
    input  logic [0:OUTPUTS-1][WIDTH-1:0]   thr_in,
    output logic [0:OUTPUTS-1]              out,
`ifdef BERN_STATS_EN
    output logic                            out_valid,
    output logic [0:OUTPUTS-1][CNT_W-1:0]   stats_cnt,
    output logic                            stats_valid
`else
    output logic                            out_valid
`endif
);

    localparam logic [LFSR_W-1:0] BASE = SEED_BASE[LFSR_W-1:0];

    if (WINDOW < 1 || CNT_W < 1 || WIDTH > LFSR_W || BASE == '0) begin : g_bad_params
        $error("bernoulli_lfsr_array: illegal parameter combination");
    end

    logic [LFSR_W-1:0]             state [OUTPUTS];
    logic [0:OUTPUTS-1][WIDTH-1:0] thr;
    logic [0:OUTPUTS-1]            hit;

    for (genvar i = 0; i < OUTPUTS; i++) begin : g_ch
        localparam logic [LFSR_W-1:0] SALT    = LFSR_W'(salt(i));
        localparam logic [LFSR_W-1:0] RST_RAW = BASE ^ SALT;
        localparam logic [LFSR_W-1:0] RST_VAL = (RST_RAW == '0) ? BASE : RST_RAW;

        logic [LFSR_W-1:0] ld_raw;
        logic [LFSR_W-1:0] ld_val;

        // A seed that cancels the salt would lock the LFSR at zero.
        assign ld_raw = seed ^ SALT;
        assign ld_val = (ld_raw == '0) ? BASE : ld_raw;

        bernoulli_lfsr #(
            .LFSR_W    (LFSR_W),
            .RESET_VAL (RST_VAL)
        ) u_lfsr (
            .clk      (clk),
            .rst      (rst),
            .load     (seed_load),
            .load_val (ld_val),
            .step     (en),
            .state    (state[i])
        );
    end

    // NOTE: default assignment first so no path through always_comb infers a latch.
    always_comb begin
        hit = '0;
        for (int i = 0; i < OUTPUTS; i++) begin
            hit[i] = (WIDTH'(lfsr_step(32'(state[i]), LFSR_W)) < thr[i]) || (thr[i] == '1);
        end
    end

    // NOTE: the threshold array is small register state, so it is reset like any flop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            thr       <= '0;
            out       <= '0;
            out_valid <= 1'b0;
        end else begin
            if (thr_we) begin
                thr <= thr_in;
            end
            if (seed_load) begin
                out_valid <= 1'b0;
            end else if (en) begin
                out       <= hit;
                out_valid <= 1'b1;
            end else begin
                out_valid <= 1'b0;
            end
        end
    end

`ifdef BERN_STATS_EN
    logic [CNT_W-1:0] ones [OUTPUTS];
    logic [CNT_W-1:0] n_samp;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            n_samp      <= '0;
            stats_cnt   <= '0;
            stats_valid <= 1'b0;
            for (int i = 0; i < OUTPUTS; i++) ones[i] <= '0;
        end else begin
            stats_valid <= 1'b0;
            if (seed_load) begin
                n_samp <= '0;
                for (int i = 0; i < OUTPUTS; i++) ones[i] <= '0;
            end else if (en) begin
                if (n_samp == CNT_W'(WINDOW - 1)) begin
                    stats_valid <= 1'b1;
                    n_samp      <= '0;
                    for (int i = 0; i < OUTPUTS; i++) begin
                        stats_cnt[i] <= ones[i] + CNT_W'(hit[i]);
                        ones[i]      <= '0;
                    end
                end else begin
                    n_samp <= n_samp + CNT_W'(1);
                    for (int i = 0; i < OUTPUTS; i++) ones[i] <= ones[i] + CNT_W'(hit[i]);
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_bernoulli_lfsr_array.sv
// Self-checking bench for bernoulli_lfsr_array: constant vector table, statistics,
// reseed repeatability, zero substitution, async reset and randomized model comparison.
module tb_bernoulli_lfsr_array;
    import bernoulli_pkg::*;

    localparam int N  = 4;
    localparam int W  = 7;
    localparam int LW = 16;
`ifdef BERN_STATS_EN
    localparam int WIN = 16;
`else
    localparam int WIN = 1024;
`endif
    localparam int CW = $clog2(WIN + 1);

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  en;
    logic                  seed_load;
    logic [LW-1:0]         seed;
    logic                  thr_we;
    logic [0:N-1][W-1:0]   thr_in;
    logic [0:N-1]          out;
    logic                  out_valid;
`ifdef BERN_STATS_EN
    logic [0:N-1][CW-1:0]  stats_cnt;
    logic                  stats_valid;
`endif

    bernoulli_lfsr_array #(
        .OUTPUTS   (N),
        .WIDTH     (W),
        .LFSR_W    (LW),
        .SEED_BASE (32'h0000_ACE1),
        .WINDOW    (WIN)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .seed_load   (seed_load),
        .seed        (seed),
        .thr_we      (thr_we),
        .thr_in      (thr_in),
        .out         (out),
`ifdef BERN_STATS_EN
        .out_valid   (out_valid),
        .stats_cnt   (stats_cnt),
        .stats_valid (stats_valid)
`else
        .out_valid   (out_valid)
`endif
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic check_range(input string name, input int act, input int lo, input int hi);
        checks++;
        if (act < lo || act > hi) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d..%0d", name, act, lo, hi);
        end
    endtask

    // Reference model: spec-level rules on plain arrays.
    lfsr_t        m_lfsr [N];
    thr_t         m_thr  [N];
    logic [0:N-1] m_out;
    logic         m_valid;

    function automatic lfsr_t salt16(input int i);
        return 16'(i * 32'h9E37);
    endfunction

    function automatic lfsr_t galois(input lfsr_t s);
        return s[0] ? ((s >> 1) ^ 16'hB400) : (s >> 1);
    endfunction

    function automatic lfsr_t seeded(input lfsr_t sd, input int i);
        lfsr_t v = sd ^ salt16(i);
        return (v == 16'h0) ? 16'hACE1 : v;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_lfsr[i] = seeded(16'hACE1, i);
            m_thr[i]  = '0;
        end
        m_out   = '0;
        m_valid = 1'b0;
    endtask

    task automatic model_edge(input logic e, input logic sl, input logic twe,
                              input logic [0:N-1][W-1:0] tin, input lfsr_t sd);
        if (sl) begin
            for (int i = 0; i < N; i++) m_lfsr[i] = seeded(sd, i);
            m_valid = 1'b0;
        end else if (e) begin
            for (int i = 0; i < N; i++) begin
                m_lfsr[i] = galois(m_lfsr[i]);
                m_out[i]  = (int'(m_lfsr[i] % 128) < int'(m_thr[i])) || (m_thr[i] == 7'h7F);
            end
            m_valid = 1'b1;
        end else begin
            m_valid = 1'b0;
        end
        if (twe) for (int i = 0; i < N; i++) m_thr[i] = tin[i];
    endtask

    task automatic cyc(input logic e, input logic sl, input logic twe,
                       input logic [0:N-1][W-1:0] tin, input lfsr_t sd, input string tag);
        en = e; seed_load = sl; thr_we = twe; thr_in = tin; seed = sd;
        @(posedge clk);
        model_edge(e, sl, twe, tin, sd);
        #1;
        check({tag, "_out"}, 64'(out), 64'(m_out));
        check({tag, "_valid"}, 64'(out_valid), 64'(m_valid));
    endtask

    typedef struct {
        logic                e;
        logic                sl;
        logic                twe;
        logic [0:N-1][W-1:0] tin;
        logic [0:N-1]        exp_out;
        logic                exp_valid;
    } vec_t;

    vec_t         tbl [8];
    int           ones [N];
    logic [0:N-1] seq_a [256];
    logic [0:N-1] seq_b [256];

    initial begin
        int diffs, chan_diff, toggles;
        logic prev;
        logic [0:N-1][W-1:0] z, t;

        z = '0;
        tbl[0] = '{1'b1, 1'b0, 1'b1, {7'd0, 7'd127, 7'd0, 7'd127}, 4'b0000, 1'b1};
        tbl[1] = '{1'b1, 1'b0, 1'b0, z,                            4'b0101, 1'b1};
        tbl[2] = '{1'b1, 1'b1, 1'b0, z,                            4'b0101, 1'b0};
        tbl[3] = '{1'b0, 1'b0, 1'b0, z,                            4'b0101, 1'b0};
        tbl[4] = '{1'b1, 1'b0, 1'b1, {4{7'd127}},                  4'b0101, 1'b1};
        tbl[5] = '{1'b1, 1'b0, 1'b0, z,                            4'b1111, 1'b1};
        tbl[6] = '{1'b0, 1'b0, 1'b1, z,                            4'b1111, 1'b0};
        tbl[7] = '{1'b1, 1'b0, 1'b0, z,                            4'b0000, 1'b1};

        rst = 1'b1; en = 1'b0; seed_load = 1'b0; seed = '0; thr_we = 1'b0; thr_in = '0;
        #12;
        check("reset_out", 64'(out), 64'h0);
        check("reset_valid", 64'(out_valid), 64'h0);
        @(negedge clk);
        rst = 1'b0;
        model_reset();

        for (int k = 0; k < 8; k++) begin
            en = tbl[k].e; seed_load = tbl[k].sl; thr_we = tbl[k].twe;
            thr_in = tbl[k].tin; seed = 16'h1234;
            @(posedge clk);
            model_edge(tbl[k].e, tbl[k].sl, tbl[k].twe, tbl[k].tin, 16'h1234);
            #1;
            check($sformatf("tbl%0d_out", k), 64'(out), 64'(tbl[k].exp_out));
            check($sformatf("tbl%0d_valid", k), 64'(out_valid), 64'(tbl[k].exp_valid));
        end

        // Long-run hit rates.
        cyc(1'b0, 1'b0, 1'b1, {7'd0, 7'd64, 7'd96, 7'd127}, '0, "stat_thr");
        for (int i = 0; i < N; i++) ones[i] = 0;
        for (int k = 0; k < 10000; k++) begin
            cyc(1'b1, 1'b0, 1'b0, z, '0, "stat");
            for (int i = 0; i < N; i++) ones[i] += int'(out[i]);
        end
        check_range("stat_ch0", ones[0], 0, 0);
        check_range("stat_ch1", ones[1], 4700, 5300);
        check_range("stat_ch2", ones[2], 7200, 7800);
        check_range("stat_ch3", ones[3], 10000, 10000);

        // Reseed repeatability.
        cyc(1'b0, 1'b0, 1'b1, {4{7'd64}}, '0, "rep_thr");
        cyc(1'b0, 1'b1, 1'b0, z, 16'h1234, "rep_load_a");
        for (int k = 0; k < 256; k++) begin
            cyc(1'b1, 1'b0, 1'b0, z, '0, "rep_a");
            seq_a[k] = out;
        end
        cyc(1'b0, 1'b1, 1'b0, z, 16'h1234, "rep_load_b");
        for (int k = 0; k < 256; k++) begin
            cyc(1'b1, 1'b0, 1'b0, z, '0, "rep_b");
            seq_b[k] = out;
        end
        diffs = 0; chan_diff = 0;
        for (int k = 0; k < 256; k++) begin
            if (seq_a[k] !== seq_b[k]) diffs++;
            if (seq_a[k][0] !== seq_a[k][1]) chan_diff++;
        end
        check("rep_identical_diffs", 64'(diffs), 64'h0);
        check("rep_ch0_ch1_differ", 64'(chan_diff > 0), 64'h1);

        // Seed equal to salt(0): channel 0 must fall back to the base seed.
        cyc(1'b0, 1'b1, 1'b0, z, salt16(0), "zs_load");
        toggles = 0; prev = out[0];
        for (int k = 0; k < 64; k++) begin
            cyc(1'b1, 1'b0, 1'b0, z, '0, "zs");
            if (out[0] !== prev) toggles++;
            prev = out[0];
        end
        check("zs_toggles", 64'(toggles > 0), 64'h1);

        // Asynchronous reset mid-run.
        cyc(1'b0, 1'b0, 1'b1, {4{7'd127}}, '0, "ar_thr");
        cyc(1'b1, 1'b0, 1'b0, z, '0, "ar_pre");
        en = 1'b1;
        #1;
        rst = 1'b1;
        #1;
        check("ar_out_async", 64'(out), 64'h0);
        check("ar_valid_async", 64'(out_valid), 64'h0);
        @(posedge clk);
        #2;
        rst = 1'b0; en = 1'b0;
        model_reset();
        cyc(1'b0, 1'b0, 1'b1, {7'd64, 7'd32, 7'd96, 7'd100}, '0, "ar_thr2");
        for (int k = 0; k < 32; k++) cyc(1'b1, 1'b0, 1'b0, z, '0, "ar_post");

        // Randomized traffic against the model.
        for (int k = 0; k < 2000; k++) begin
            for (int i = 0; i < N; i++) t[i] = 7'($urandom_range(0, 127));
            cyc(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 63) == 0),
                1'($urandom_range(0, 15) == 0), t, 16'($urandom), "rand");
        end

`ifdef BERN_STATS_EN
        // Continuous en: pulse on every 16th sample with a full count.
        cyc(1'b0, 1'b1, 1'b1, {4{7'd127}}, 16'h00FF, "st_load");
        for (int k = 1; k <= 48; k++) begin
            cyc(1'b1, 1'b0, 1'b0, z, '0, "st_cont");
            check($sformatf("st_cont_pulse%0d", k), 64'(stats_valid), 64'((k % 16) == 0));
            if ((k % 16) == 0) check("st_cont_cnt0", 64'(stats_cnt[0]), 64'd16);
        end
        // 50% gapped en: pulse every 32 cycles.
        cyc(1'b0, 1'b1, 1'b0, z, 16'h00FF, "st_load2");
        for (int k = 1; k <= 96; k++) begin
            cyc(1'(k % 2), 1'b0, 1'b0, z, '0, "st_gap");
            check($sformatf("st_gap_pulse%0d", k), 64'(stats_valid), 64'((k % 32) == 31));
        end
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
